// File: rtl/inst_encoder.sv
// inst_encoder: two-stage pipelined RISC-V instruction encoder.
//
// S1 registers a request (opcode, imm, register fields, funct3). S2 holds the
// packed 32-bit instruction and an error flag. Both stages move together
// whenever S2 is empty or its result is being taken.
//
// Build option: define INST_ENCODER_RANGE_CHECK_EN to flag immediates that do
// not fit the selected format. Without it, imm is truncated to the encoded bits.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   in_valid/in_ready request handshake
//   opcode, imm, rd, rs1, rs2, funct3   request fields
//   out_valid/out_ready result handshake
//   inst_code, err    encoded instruction and not-encodable flag
//   enc_count         number of completed result transfers (wraps)
module inst_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [31:0]      imm,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst_code,
    output logic             err,
    output logic [CNT_W-1:0] enc_count
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    // Stage 1: registered request
    logic        s1_valid;
    logic [6:0]  s1_opcode;
    logic [31:0] s1_imm;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;

    // Stage 2: packed result
    logic        s2_valid;
    logic [31:0] s2_code;
    logic        s2_err;

    logic        s2_adv;
    logic [31:0] enc_code;
    logic        enc_err;
    logic        bad_op;
    logic        range_bad;

    assign s2_adv    = !s2_valid || out_ready;
    // Held low during reset so no request is accepted into a clearing pipe.
    assign in_ready  = !reset && (!s1_valid || s2_adv);
    assign out_valid = s2_valid;
    assign inst_code = s2_code;
    assign err       = s2_err;

`ifdef INST_ENCODER_RANGE_CHECK_EN
    logic signed [31:0] s1_simm;
    assign s1_simm = $signed(s1_imm);
`endif

    always_comb begin
        enc_code  = 32'd0;
        bad_op    = 1'b0;
        range_bad = 1'b0;
        unique case (s1_opcode)
            OpLoad, OpImm, OpJalr: begin
                enc_code = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
`ifdef INST_ENCODER_RANGE_CHECK_EN
                range_bad = (s1_simm < -2048) || (s1_simm > 2047);
`endif
            end
            OpStore: begin
                enc_code = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
`ifdef INST_ENCODER_RANGE_CHECK_EN
                range_bad = (s1_simm < -2048) || (s1_simm > 2047);
`endif
            end
            OpBranch: begin
                enc_code = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                            s1_imm[4:1], s1_imm[11], s1_opcode};
`ifdef INST_ENCODER_RANGE_CHECK_EN
                range_bad = (s1_simm < -4096) || (s1_simm > 4094) || s1_imm[0];
`endif
            end
            OpJal: begin
                enc_code = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd,
                            s1_opcode};
`ifdef INST_ENCODER_RANGE_CHECK_EN
                range_bad = (s1_simm < -1048576) || (s1_simm > 1048574) || s1_imm[0];
`endif
            end
            OpLui: begin
                enc_code = {s1_imm[31:12], s1_rd, s1_opcode};
`ifdef INST_ENCODER_RANGE_CHECK_EN
                range_bad = (s1_imm[11:0] != 12'd0);
`endif
            end
            default: begin
                bad_op = 1'b1;
            end
        endcase
        enc_err = bad_op || range_bad;
        // An error result never carries a partial encoding.
        if (enc_err) begin
            enc_code = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_code   <= 32'd0;
            s2_err    <= 1'b0;
            enc_count <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_opcode <= opcode;
                    s1_imm    <= imm;
                    s1_rd     <= rd;
                    s1_rs1    <= rs1;
                    s1_rs2    <= rs2;
                    s1_funct3 <= funct3;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                // Keep the outputs quiet when a bubble moves into S2.
                if (s1_valid) begin
                    s2_code <= enc_code;
                    s2_err  <= enc_err;
                end else begin
                    s2_code <= 32'd0;
                    s2_err  <= 1'b0;
                end
            end
            if (s2_valid && out_ready) begin
                enc_count <= enc_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed and randomised stimulus for inst_encoder with a
// result scoreboard. The counter is built narrow so wrap-around is exercised.
module tb_inst_encoder;

    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    opcode;
    logic [31:0]   imm;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   inst_code;
    logic          err;
    logic [CW-1:0] enc_count;

    always #5 clk = ~clk;

    inst_encoder #(.CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .imm       (imm),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst_code (inst_code),
        .err       (err),
        .enc_count (enc_count)
    );

    int          checks = 0;
    int          errors = 0;
    logic [32:0] sb[$];
    int unsigned model_cnt = 0;
    logic        stall_prev = 1'b0;
    logic [32:0] held = '0;
    logic        rnd_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoding, {err, inst_code}.
    function automatic logic [32:0] model(input logic [6:0] op, input logic [31:0] im,
                                          input logic [4:0] d, input logic [4:0] a,
                                          input logic [4:0] b, input logic [2:0] f3);
        logic [31:0] c;
        logic        e;
        longint      s;
        c = 32'd0;
        e = 1'b0;
        s = longint'($signed(im));
        case (op)
            7'h03, 7'h13, 7'h67: begin
                c = (32'(im[11:0]) << 20) | (32'(a) << 15) | (32'(f3) << 12)
                    | (32'(d) << 7) | 32'(op);
`ifdef INST_ENCODER_RANGE_CHECK_EN
                if (s < -2048 || s > 2047) e = 1'b1;
`endif
            end
            7'h23: begin
                c = (32'(im[11:5]) << 25) | (32'(b) << 20) | (32'(a) << 15)
                    | (32'(f3) << 12) | (32'(im[4:0]) << 7) | 32'(op);
`ifdef INST_ENCODER_RANGE_CHECK_EN
                if (s < -2048 || s > 2047) e = 1'b1;
`endif
            end
            7'h63: begin
                c = (32'(im[12]) << 31) | (32'(im[10:5]) << 25) | (32'(b) << 20)
                    | (32'(a) << 15) | (32'(f3) << 12) | (32'(im[4:1]) << 8)
                    | (32'(im[11]) << 7) | 32'(op);
`ifdef INST_ENCODER_RANGE_CHECK_EN
                if (s < -4096 || s > 4094 || im[0]) e = 1'b1;
`endif
            end
            7'h6F: begin
                c = (32'(im[20]) << 31) | (32'(im[10:1]) << 21) | (32'(im[11]) << 20)
                    | (32'(im[19:12]) << 12) | (32'(d) << 7) | 32'(op);
`ifdef INST_ENCODER_RANGE_CHECK_EN
                if (s < -1048576 || s > 1048574 || im[0]) e = 1'b1;
`endif
            end
            7'h37: begin
                c = (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
`ifdef INST_ENCODER_RANGE_CHECK_EN
                if (im[11:0] != 12'd0) e = 1'b1;
`endif
            end
            default: e = 1'b1;
        endcase
        if (e) c = 32'd0;
        return {e, c};
    endfunction

    // Drive one request and push its expected result when the transfer happens.
    task automatic send(input logic [6:0] op, input logic [31:0] im, input logic [4:0] d,
                        input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                        input logic [32:0] exp);
        logic acc;
        acc      = 1'b0;
        opcode   = op;
        imm      = im;
        rd       = d;
        rs1      = a;
        rs2      = b;
        funct3   = f3;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL accept_timeout: observed not accepted expected accepted");
        end
        in_valid = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on each result transfer, checks hold
    // stability during back-pressure and tracks the expected transfer count.
    always @(negedge clk) begin
        if (reset) begin
            model_cnt  = 0;
            stall_prev = 1'b0;
        end else begin
            chk("enc_count", 64'(enc_count), 64'(model_cnt[CW-1:0]));
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'({err, inst_code}), 64'(held));
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_result: observed %0h expected none",
                           {err, inst_code});
                end
                if (sb.size() != 0) begin
                    chk("result", 64'({err, inst_code}), 64'(sb.pop_front()));
                end
                model_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            held       = {err, inst_code};
        end
    end

    always @(posedge clk) begin
        if (rnd_mode) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [6:0]  ops [9];
        logic [6:0]  op;
        logic [31:0] im;
        logic [4:0]  d, a, b;
        logic [2:0]  f3;

        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h33, 7'h7F};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = '0;
        imm       = '0;
        rd        = '0;
        rs1       = '0;
        rs2       = '0;
        funct3    = '0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_inst_code", 64'(inst_code), 64'd0);
        chk("rst_enc_count", 64'(enc_count), 64'd0);
        reset = 1'b0;

        // Back-pressure: two accepted, third blocked, first result held.
        out_ready = 1'b0;
        send(7'h13, 32'd5, 5'd1, 5'd0, 5'd0, 3'd0, {1'b0, 32'h0050_0093});
        send(7'h23, 32'd8, 5'd0, 5'd0, 5'd2, 3'd2, {1'b0, 32'h0020_2423});
        opcode   = 7'h63;
        imm      = 32'hFFFF_FFFC;
        rs1      = 5'd0;
        rs2      = 5'd0;
        funct3   = 3'd0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_first_code", 64'(inst_code), 64'h0050_0093);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(7'h63, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd0, 3'd0, {1'b0, 32'hFE00_0EE3});
        @(negedge clk);
        chk("drain_b", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("drain_c", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("drain_idle", 64'(out_valid), 64'd0);
        chk("count_three", 64'(enc_count), 64'd3);

        // Directed encodings
        @(posedge clk);
        #1;
        send(7'h6F, 32'd2048, 5'd1, 5'd0, 5'd0, 3'd0, {1'b0, 32'h0010_00EF});
        send(7'h37, 32'h1234_5000, 5'd5, 5'd0, 5'd0, 3'd0, {1'b0, 32'h1234_52B7});
`ifdef INST_ENCODER_RANGE_CHECK_EN
        send(7'h13, 32'd2048, 5'd1, 5'd0, 5'd0, 3'd0, {1'b1, 32'h0});
        send(7'h63, 32'd3, 5'd0, 5'd1, 5'd2, 3'd0, {1'b1, 32'h0});
`else
        send(7'h13, 32'd2048, 5'd1, 5'd0, 5'd0, 3'd0, {1'b0, 32'h8000_0093});
        send(7'h63, 32'd3, 5'd0, 5'd1, 5'd2, 3'd0, {1'b0, 32'h0020_8163});
`endif
        send(7'h33, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0, {1'b1, 32'h0});
        repeat (4) @(posedge clk);
        #1;
        chk("directed_drained", 64'(sb.size()), 64'd0);

        // Reset with two requests in flight
        send(7'h13, 32'd1, 5'd3, 5'd4, 5'd0, 3'd0, model(7'h13, 32'd1, 5'd3, 5'd4, 5'd0, 3'd0));
        send(7'h13, 32'd2, 5'd3, 5'd4, 5'd0, 3'd0, model(7'h13, 32'd2, 5'd3, 5'd4, 5'd0, 3'd0));
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_count", 64'(enc_count), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 64'd0);
        end

        // Random traffic with random back-pressure
        @(posedge clk);
        #1;
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 1)
                im = 32'($signed($urandom_range(0, 8191)) - 4096);
            else
                im = $urandom;
            d  = 5'($urandom);
            a  = 5'($urandom);
            b  = 5'($urandom);
            f3 = 3'($urandom);
            send(op, im, d, a, b, f3, model(op, im, d, a, b, f3));
        end
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("random_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
